// File: rtl/vx_tcu_bhf_mul_arb.sv
`default_nettype none
// ============================================================================
// Module   : vx_tcu_bhf_mul_arb
// Brief    : Round-robin arbiter sharing one BF16 multiplier among NUM_REQS
//            lanes, with an in-order LATENCY-deep result pipeline.
//            Optional perf counters: VX_TCU_BHF_MUL_ARB_PERF_EN
// Revision : 1.0
// ============================================================================
module vx_tcu_bhf_mul_arb #(
    parameter int NUM_REQS = 4,
    parameter int LATENCY  = 2,
    parameter int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_REQS-1:0]    req_valid_i,
    input  logic [NUM_REQS*16-1:0] req_a_i,
    input  logic [NUM_REQS*16-1:0] req_b_i,
    output logic [NUM_REQS-1:0]    req_ready_o,
    output logic                   mul_enable_o,
    output logic [15:0]            mul_a_o,
    output logic [15:0]            mul_b_o,
    input  logic [32:0]            mul_y_i,
    output logic                   rsp_valid_o,
    output logic [IDX_W-1:0]       rsp_idx_o,
    output logic [32:0]            rsp_data_o,
    input  logic                   rsp_ready_i,
    output logic                   busy_o,
    output logic [31:0]            perf_issue_cnt_o,
    output logic [31:0]            perf_stall_cnt_o
);

    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_d;
    logic [IDX_W-1:0]   w_grant;
    logic               w_any;
    logic               w_stall;
    logic               w_fire;

    logic [LATENCY-1:0] stg_valid_q;
    logic [IDX_W-1:0]   stg_idx_q  [LATENCY];
    logic [32:0]        stg_data_q [LATENCY];

    assign w_any   = |req_valid_i;
    assign w_stall = stg_valid_q[LATENCY-1] & ~rsp_ready_i;
    assign w_fire  = w_any & ~w_stall & ~reset_i;

    // Rotating priority search starting at rr_ptr; falls back to rr_ptr when idle.
    always_comb begin
        int   pos;
        logic found;
        pos     = 0;
        found   = 1'b0;
        w_grant = rr_ptr_q;
        for (int k = 0; k < NUM_REQS; k++) begin
            pos = int'(rr_ptr_q) + k;
            if (pos >= NUM_REQS) begin
                pos = pos - NUM_REQS;
            end
            if (!found && req_valid_i[pos]) begin
                found   = 1'b1;
                w_grant = IDX_W'(pos);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_fire) begin
            rr_ptr_d = (int'(w_grant) == NUM_REQS - 1) ? '0 : w_grant + 1'b1;
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            req_ready_o[i] = w_fire && (int'(w_grant) == i);
        end
    end

    assign mul_enable_o = w_fire;
    assign mul_a_o      = req_a_i[16*w_grant +: 16];
    assign mul_b_o      = req_b_i[16*w_grant +: 16];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Whole pipeline freezes on stall so the output stage stays stable.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stg_valid_q <= '0;
        end else if (!w_stall) begin
            stg_valid_q[0] <= w_fire;
            for (int k = 1; k < LATENCY; k++) begin
                stg_valid_q[k] <= stg_valid_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!w_stall) begin
            stg_idx_q[0]  <= w_grant;
            stg_data_q[0] <= mul_y_i;
            for (int k = 1; k < LATENCY; k++) begin
                stg_idx_q[k]  <= stg_idx_q[k-1];
                stg_data_q[k] <= stg_data_q[k-1];
            end
        end
    end

    assign rsp_valid_o = stg_valid_q[LATENCY-1];
    assign rsp_idx_o   = stg_idx_q[LATENCY-1];
    assign rsp_data_o  = stg_data_q[LATENCY-1];
    assign busy_o      = |stg_valid_q;

`ifdef VX_TCU_BHF_MUL_ARB_PERF_EN
    logic [31:0] perf_issue_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (w_fire) begin
                perf_issue_q <= perf_issue_q + 32'd1;
            end
            if (w_stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt_o = perf_issue_q;
    assign perf_stall_cnt_o = perf_stall_q;
`else
    assign perf_issue_cnt_o = '0;
    assign perf_stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_tcu_bhf_mul_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_tcu_bhf_mul_arb
// Brief    : Self-checking bench: grant table, rotation, stall, reset, perf.
// Revision : 1.0
// ============================================================================
module tb_vx_tcu_bhf_mul_arb;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int IW  = 2;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N-1:0]    req_valid;
    logic [N*16-1:0] req_a;
    logic [N*16-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            mul_enable;
    logic [15:0]     mul_a;
    logic [15:0]     mul_b;
    logic [32:0]     mul_y;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_idx;
    logic [32:0]     rsp_data;
    logic            rsp_ready;
    logic            busy;
    logic [31:0]     perf_issue_cnt;
    logic [31:0]     perf_stall_cnt;

    always #5 clk = ~clk;

    function automatic logic [32:0] model_y(input logic [15:0] a, input logic [15:0] b);
        return {a[15] ^ b[15], a, b};
    endfunction

    // Stand-in multiplier: any injective function of the operands exposes routing errors.
    assign mul_y = model_y(mul_a, mul_b);

    vx_tcu_bhf_mul_arb #(
        .NUM_REQS (N),
        .LATENCY  (LAT),
        .IDX_W    (IW)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .req_valid_i      (req_valid),
        .req_a_i          (req_a),
        .req_b_i          (req_b),
        .req_ready_o      (req_ready),
        .mul_enable_o     (mul_enable),
        .mul_a_o          (mul_a),
        .mul_b_o          (mul_b),
        .mul_y_i          (mul_y),
        .rsp_valid_o      (rsp_valid),
        .rsp_idx_o        (rsp_idx),
        .rsp_data_o       (rsp_data),
        .rsp_ready_i      (rsp_ready),
        .busy_o           (busy),
        .perf_issue_cnt_o (perf_issue_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
    );

    typedef struct {
        logic [IW-1:0] idx;
        logic [32:0]   data;
        int            cyc;
    } sb_t;

    typedef struct packed {
        logic [N-1:0] valid;
        logic [N-1:0] ready;
    } vec_t;

    sb_t         sb[$];
    sb_t         mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          mdl_ptr  = 0;
    bit          chk_lat  = 1'b0;
    logic [15:0] op_a [N];
    logic [15:0] op_b [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Response monitor: every accepted response must match the oldest expected issue.
    always @(negedge clk) begin
        if (!reset_i && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: actual idx=%0d data=%0h required=no response", rsp_idx, rsp_data);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_idx", 64'(rsp_idx), 64'(mon_e.idx));
                chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
                if (chk_lat) begin
                    chk("rsp_latency", 64'(cyc - mon_e.cyc), 64'(LAT));
                end
            end
        end
    end

    task automatic set_ops(input int e);
        for (int i = 0; i < N; i++) begin
            // Offset by 2 so lane 2 of the first vector carries 0x3F80 / 0x4000.
            op_a[i] = 16'h3F80 + 16'(e * 16) + 16'(i) - 16'd2;
            op_b[i] = 16'h4000 + 16'(e * 16) + 16'(i) - 16'd2;
        end
    endtask

    // Called at posedge+1; drives one cycle, checks at negedge, returns at next posedge+1.
    task automatic drive_check(input string tag, input logic [N-1:0] valid,
                               input logic rdy, input logic [N-1:0] exp_ready);
        int  g;
        sb_t ent;
        req_valid = valid;
        rsp_ready = rdy;
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = op_a[i];
            req_b[16*i +: 16] = op_b[i];
        end
        @(negedge clk);
        chk({tag, "/req_ready"}, 64'(req_ready), 64'(exp_ready));
        chk({tag, "/mul_enable"}, 64'(mul_enable), 64'(|exp_ready));
        if (|exp_ready) begin
            g = 0;
            for (int i = 0; i < N; i++) begin
                if (exp_ready[i]) g = i;
            end
            chk({tag, "/mul_a"}, 64'(mul_a), 64'(op_a[g]));
            chk({tag, "/mul_b"}, 64'(mul_b), 64'(op_b[g]));
            ent.idx  = IW'(g);
            ent.data = model_y(op_a[g], op_b[g]);
            ent.cyc  = cyc;
            sb.push_back(ent);
            mdl_ptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_i   = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        sb.delete();
        mdl_ptr = 0;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl [10];
        logic [N-1:0] er;

        // Hand-derived grant sequence starting from rr_ptr=0 after reset.
        tbl[0] = '{valid: 4'b0100, ready: 4'b0100};
        tbl[1] = '{valid: 4'b1111, ready: 4'b1000};
        tbl[2] = '{valid: 4'b1111, ready: 4'b0001};
        tbl[3] = '{valid: 4'b0000, ready: 4'b0000};
        tbl[4] = '{valid: 4'b1010, ready: 4'b0010};
        tbl[5] = '{valid: 4'b1010, ready: 4'b1000};
        tbl[6] = '{valid: 4'b1010, ready: 4'b0010};
        tbl[7] = '{valid: 4'b0001, ready: 4'b0001};
        tbl[8] = '{valid: 4'b0011, ready: 4'b0010};
        tbl[9] = '{valid: 4'b0011, ready: 4'b0001};

        set_ops(0);
        reset_i   = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = op_a[i];
            req_b[16*i +: 16] = op_b[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset/req_ready", 64'(req_ready), 64'd0);
        chk("reset/mul_enable", 64'(mul_enable), 64'd0);
        chk("reset/rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset/busy", 64'(busy), 64'd0);
        chk("reset/perf_issue", 64'(perf_issue_cnt), 64'd0);
        chk("reset/perf_stall", 64'(perf_stall_cnt), 64'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        mdl_ptr = 0;
        chk_lat = 1'b1;

        for (int e = 0; e < 10; e++) begin
            set_ops(e);
            drive_check($sformatf("tbl%0d", e), tbl[e].valid, 1'b1, tbl[e].ready);
        end

        // All lanes requesting: strict rotation, one fire per cycle.
        for (int s = 0; s < 8; s++) begin
            set_ops(20 + s);
            er = N'(1) << mdl_ptr;
            drive_check("rotate", '1, 1'b1, er);
        end

        // Output stalled with a full pipeline: nothing issues, response held.
        chk_lat = 1'b0;
        begin
            logic [31:0] s0;
            s0 = perf_stall_cnt;
            for (int s = 0; s < 5; s++) begin
                drive_check("stall", '1, 1'b0, '0);
                chk("stall/rsp_valid", 64'(rsp_valid), 64'd1);
                chk("stall/rsp_idx", 64'(rsp_idx), 64'(sb[0].idx));
                chk("stall/rsp_data", 64'(rsp_data), 64'(sb[0].data));
            end
`ifdef VX_TCU_BHF_MUL_ARB_PERF_EN
            chk("stall/perf_stall", 64'(perf_stall_cnt), 64'(s0 + 32'd5));
`else
            chk("stall/perf_stall", 64'(perf_stall_cnt), 64'(s0 & 32'd0));
`endif
        end
        for (int s = 0; s < 4; s++) begin
            set_ops(40 + s);
            er = N'(1) << mdl_ptr;
            drive_check("resume", '1, 1'b1, er);
        end
        for (int s = 0; s < 3; s++) drive_check("drain1", '0, 1'b1, '0);
        chk("drain1/sb_empty", 64'(sb.size()), 64'd0);
        chk("drain1/busy", 64'(busy), 64'd0);

        // Reset with two lane-2 entries in flight (rr_ptr ends at 3).
        chk_lat = 1'b1;
        set_ops(50);
        drive_check("inflight", 4'b0100, 1'b1, 4'b0100);
        drive_check("inflight", 4'b0100, 1'b1, 4'b0100);
        chk("inflight/busy", 64'(busy), 64'd1);
        pulse_reset();
        for (int s = 0; s < 3; s++) begin
            drive_check("post_rst_idle", '0, 1'b1, '0);
            chk("post_rst/no_stale", 64'(rsp_valid), 64'd0);
        end
        set_ops(51);
        drive_check("post_rst_grant", 4'b1010, 1'b1, 4'b0010);
        for (int s = 0; s < 3; s++) drive_check("drain2", '0, 1'b1, '0);
        chk("drain2/sb_empty", 64'(sb.size()), 64'd0);

        // Ten issues from a clean reset for the issue counter.
        pulse_reset();
        for (int s = 0; s < 10; s++) begin
            set_ops(60 + s);
            drive_check("perf", 4'b0001, 1'b1, 4'b0001);
        end
`ifdef VX_TCU_BHF_MUL_ARB_PERF_EN
        chk("perf_issue_cnt", 64'(perf_issue_cnt), 64'd10);
`else
        chk("perf_issue_cnt", 64'(perf_issue_cnt), 64'd0);
`endif
        for (int s = 0; s < 3; s++) drive_check("drain3", '0, 1'b1, '0);
        chk("drain3/sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vx_tcu_bhf_mul_arb.md
Name: VX_tcu_bhf_mul_arb

Overview:
- Round-robin arbiter and pipeline sequencer that shares one combinational BF16 multiply datapath among NUM_REQS requester lanes of the TCU BHF unit.
- Datapath: BF16×BF16 → recoded FP32, 33 bits.
- Accepts operand pairs over valid/ready, drives the shared multiplier, and carries result and requester index through a LATENCY-deep registered pipeline.
- Returns results in issue order over a single valid/ready response port.

Parameters:
- NUM_REQS, 4, number of requester lanes (≥1).
- LATENCY, 2, registered pipeline stages from issue to response (≥1).
- IDX_W, `CLOG2(NUM_REQS) (min 1), width of the requester index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQS  per-lane operand valid.
- req_a  in  NUM_REQS*16  per-lane BF16 operand a; lane i at [16*i+:16].
- req_b  in  NUM_REQS*16  per-lane BF16 operand b.
- req_ready  out  NUM_REQS  per-lane accept.
- mul_enable  out  1  high on the issue cycle.
- mul_a  out  16  operand a to the shared multiplier.
- mul_b  out  16  operand b to the shared multiplier.
- mul_y  in  33  recoded FP32 product; combinational from mul_a/mul_b.
- rsp_valid  out  1  response valid.
- rsp_idx  out  IDX_W  lane that issued this result.
- rsp_data  out  33  recoded FP32 product.
- rsp_ready  in  1  response consumer accept.
- busy  out  1  any pipeline stage holds a valid entry.
- perf_issue_cnt  out  32  issued operations (optional feature).
- perf_stall_cnt  out  32  backpressure cycles (optional feature).

Behaviour:
- Single clock domain. All state is reset synchronously by active-high reset.
- Reset values: rr_ptr=0; all stage valids=0; rsp_valid=0; busy=0; perf counters=0.
- While reset is high: req_ready=0 and mul_enable=0.
- stall = stage_valid[LATENCY-1] & ~rsp_ready.
- Grant: the first lane i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod NUM_REQS. The search is combinational.
- req_ready[i] = (i==grant) & any(req_valid) & ~stall & ~reset. At most one req_ready is high per cycle.
- req_ready does not depend on that lane's own req_valid beyond grant selection.
- fire = any(req_valid) & ~stall & ~reset.
- mul_a/mul_b = granted lane's operands. When no valid request exists they hold lane rr_ptr's operands; they are don't-care then.
- mul_enable = fire.
- On fire, rr_ptr ← (grant+1) mod NUM_REQS (wrap NUM_REQS-1 → 0). rr_ptr holds otherwise, including during stall.
- Pipeline advance when ~stall:
  - stage0 ← {fire, grant, mul_y}.
  - stage k ← stage k-1 for 1 ≤ k < LATENCY.
- When stall, every stage holds. No bubble collapsing.
- Data/idx of invalid stages are don't-care, but must not X-propagate into valid bits.
- rsp_valid = stage_valid[LATENCY-1]; rsp_idx and rsp_data come from the same stage. Handshake completes when rsp_valid & rsp_ready.
- Handshake invariants:
  - Once rsp_valid rises, rsp_valid/rsp_idx/rsp_data stay stable until accepted.
  - A requester's req_valid must stay high with stable operands until req_ready.
- Issue-to-response latency: exactly LATENCY cycles with rsp_ready held high. Throughput is one result per cycle.
- Simultaneous accept and issue: when the output stage is accepted in the same cycle as a new fire, both occur. There is no bubble.
- Simultaneous requests from all lanes are served strictly rotating, so any lane waits at most NUM_REQS-1 grants.
- NUM_REQS==1: grant is always 0 and rr_ptr is constant 0.
- Reset mid-operation: all in-flight entries are discarded and no response is emitted for them. The first post-reset grant starts from lane 0.
- busy = OR of all stage valids.

Optional Feature:
- Macro: VX_TCU_BHF_MUL_ARB_PERF_EN.
- Defined:
  - perf_issue_cnt increments on each fire.
  - perf_stall_cnt increments on each cycle with stall=1.
  - Both are 32-bit, wrap 0xFFFFFFFF → 0, and clear on reset.
- Undefined: both ports are driven constant 0 and no counter registers are inferred.

Test Plan:
- Reset, then lane 2 alone: req_a=0x3F80, req_b=0x4000, rsp_ready=1 → mul_enable exactly one cycle with mul_a=0x3F80, mul_b=0x4000. Two cycles later (LATENCY=2), rsp_valid=1, rsp_idx=2, rsp_data = mul_y sampled at issue.
- All 4 lanes valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,1… with one fire per cycle. rsp_idx sequence is identical, delayed 2 cycles.
- Pipeline full, rsp_ready=0 for 5 cycles → req_ready all 0 and no fire. rsp_valid/idx/data stable. perf_stall_cnt +5 with macro. rr_ptr unchanged; the next grant resumes at the correct lane.
- Lanes 1 and 3 valid with rr_ptr=2 → lane 3 granted first, then lane 1. rr_ptr wraps from 3 to 0 after lane 3 fires.
- Reset asserted with 2 entries in flight → rsp_valid=0 and busy=0 the cycle after. No stale response appears afterward. The first new request from lane 1 is granted from rr_ptr=0.
- Macro undefined: 10 issues → perf_issue_cnt=0. Macro defined: same stimulus → perf_issue_cnt=10.
